// File: rtl/wb_burst_reader.sv
// Wishbone B4 burst read master. Fetches word_count consecutive 32-bit words
// from base_addr using incrementing bursts and streams them out through a
// first-word-fall-through FIFO. Strobe is throttled so the FIFO never overflows.
module wb_burst_reader #(
    parameter int ADR_W   = 32,
    parameter int CNT_W   = 16,
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ADR_W-1:0] base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             wb_cyc,
    output logic             wb_stb,
    output logic             wb_we,
    output logic [3:0]       wb_sel,
    output logic [ADR_W-1:0] wb_adr,
    output logic [2:0]       wb_cti,
    output logic [1:0]       wb_bte,
    input  logic [31:0]      wb_dat_sm,
    input  logic             wb_ack,
    input  logic             wb_err
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0] LVL_HIGH = (FIFO_AW+1)'(DEPTH - 2);

    typedef enum logic [1:0] {IDLE, BURST, FINISH} state_t;

    state_t             state, state_next;
    logic [ADR_W-1:0]   addr, addr_next;
    logic [CNT_W-1:0]   remaining, remaining_next;
    logic               stb_q, stb_next;
    logic               error_q, error_next;
    logic               zero_done, zero_done_next;

    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level, level_next;

    logic accept, beat_ok, beat_err, push, pop, last_beat;
    logic unused_bits;

    // Byte-lane bits of the base address are discarded (word aligned).
    assign unused_bits = &{1'b0, base_addr[1:0]};

    // A start in FINISH is accepted too, since busy is already low there.
    assign accept    = start && (state != BURST);
    assign beat_ok   = (state == BURST) && stb_q && wb_ack && !wb_err;
    assign beat_err  = (state == BURST) && stb_q && wb_err;
    assign push      = beat_ok;
    assign pop       = dout_valid && dout_ready;
    assign last_beat = (remaining == CNT_W'(1));

    // Next-state, address/count update and strobe throttling.
    always_comb begin
        state_next     = state;
        addr_next      = addr;
        remaining_next = remaining;
        error_next     = error_q;
        zero_done_next = 1'b0;
        level_next     = level;

        if (push && !pop) begin
            level_next = level + LVL_ONE;
        end else if (!push && pop) begin
            level_next = level - LVL_ONE;
        end

        case (state)
            IDLE, FINISH: begin
                state_next = IDLE;
                if (accept) begin
                    error_next = 1'b0;
                    if (word_count == '0) begin
                        zero_done_next = 1'b1;
                    end else begin
                        addr_next      = {base_addr[ADR_W-1:2], 2'b00};
                        remaining_next = word_count;
                        state_next     = BURST;
                    end
                end
            end
            BURST: begin
                if (beat_err) begin
                    error_next = 1'b1;
                    state_next = FINISH;
                end else if (beat_ok) begin
                    addr_next = addr + ADR_W'(4);
                    if (remaining != '0) begin
                        remaining_next = remaining - CNT_W'(1);
                    end
                    if (last_beat) begin
                        state_next = FINISH;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Registered strobe: only request a beat when the FIFO is sure to
        // have room for it after this cycle's push/pop.
        stb_next = (state_next == BURST) && (level_next <= LVL_HIGH);
    end

    // Control and address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            stb_q     <= 1'b0;
            error_q   <= 1'b0;
            zero_done <= 1'b0;
        end else begin
            state     <= state_next;
            addr      <= addr_next;
            remaining <= remaining_next;
            stb_q     <= stb_next;
            error_q   <= error_next;
            zero_done <= zero_done_next;
        end
    end

    // FIFO pointers and fill level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            level <= level_next;
        end
    end

    // FIFO storage, no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wb_dat_sm;
    end

    assign busy       = (state == BURST);
    assign done       = (state == FINISH) || zero_done;
    assign error      = error_q;
    assign dout       = mem[rd_ptr];
    assign dout_valid = (level != '0);
    assign wb_cyc     = (state == BURST);
    assign wb_stb     = stb_q;
    assign wb_we      = 1'b0;
    assign wb_sel     = 4'hF;
    assign wb_adr     = addr;
    assign wb_cti     = (state == BURST) ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
    assign wb_bte     = 2'b00;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Testbench for wb_burst_reader: Wishbone slave model backed by an
// address-derived memory, a queue-based model of the output stream and job
// status, and directed jobs with a few literal expectations.
module tb_wb_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, error;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_sm;
    logic        wb_ack, wb_err;

    wb_burst_reader #(.ADR_W(32), .CNT_W(16), .FIFO_AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .error(error),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_adr(wb_adr), .wb_cti(wb_cti), .wb_bte(wb_bte),
        .wb_dat_sm(wb_dat_sm), .wb_ack(wb_ack), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Slave: combinational ack, optional alternate-cycle stall, error at err_addr.
    logic        wait_en  = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic        tick = 1'b0;
    logic        stall;
    always @(posedge clk) tick <= ~tick;
    always_comb begin
        stall     = wait_en && tick;
        wb_ack    = wb_cyc && wb_stb && !stall && (wb_adr != err_addr);
        wb_err    = wb_cyc && wb_stb && !stall && (wb_adr == err_addr);
        wb_dat_sm = mem_word(wb_adr);
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    logic [31:0] q[$];
    logic [31:0] adr_log[$];
    logic [2:0]  cti_log[$];
    bit          job_active = 0;
    bit          done_exp = 0;
    bit          error_exp = 0;
    bit          done_next;
    logic [31:0] job_base = '0;
    int          job_count = 0;
    int          beat = 0;
    int          pop_count = 0;
    logic [31:0] first_pop = '0;

    // Per-cycle compare and model advance (inputs are stable at negedge).
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            job_active = 0;
            done_exp   = 0;
            error_exp  = 0;
            chk("rst_cyc", 32'(wb_cyc), 32'd0);
            chk("rst_dout_valid", 32'(dout_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
        end else begin
            chk("busy", 32'(busy), 32'(job_active));
            chk("cyc", 32'(wb_cyc), 32'(job_active));
            chk("done", 32'(done), 32'(done_exp));
            chk("error", 32'(error), 32'(error_exp));
            chk("dout_valid", 32'(dout_valid), 32'(q.size() != 0));
            chk("we_sel_bte", 32'({wb_we, wb_sel, wb_bte}), 32'({1'b0, 4'hF, 2'b00}));
            if (job_active) begin
                chk("stb", 32'(wb_stb), 32'(q.size() <= 14));
                chk("adr", wb_adr, job_base + 32'(4 * beat));
                chk("cti", 32'(wb_cti), (job_count - beat == 1) ? 32'd7 : 32'd2);
            end else begin
                chk("stb_idle", 32'(wb_stb), 32'd0);
            end
            if (dout_valid && q.size() != 0) chk("dout", dout, q[0]);

            done_next = 0;
            if (dout_valid && dout_ready && q.size() != 0) begin
                if (pop_count == 0) first_pop = q[0];
                void'(q.pop_front());
                pop_count++;
            end
            if (job_active && wb_stb && wb_err) begin
                error_exp  = 1;
                job_active = 0;
                done_next  = 1;
            end else if (job_active && wb_stb && wb_ack) begin
                q.push_back(mem_word(job_base + 32'(4 * beat)));
                adr_log.push_back(wb_adr);
                cti_log.push_back(wb_cti);
                beat++;
                if (beat == job_count) begin
                    job_active = 0;
                    done_next  = 1;
                end
            end else if (!job_active && start) begin
                error_exp = 0;
                if (word_count == 16'd0) begin
                    done_next = 1;
                end else begin
                    job_active = 1;
                    job_base   = {base_addr[31:2], 2'b00};
                    job_count  = int'(word_count);
                    beat       = 0;
                end
            end
            done_exp = done_next;
        end
    end

    task automatic go(input logic [31:0] b, input logic [15:0] c);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; word_count = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!dout_valid && q.size() == 0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: fifo not drained within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic 4-word burst
        adr_log.delete(); cti_log.delete(); pop_count = 0;
        go(32'h0000_0100, 16'd4);
        wait_done(50, "t1_done");
        wait_drain(50, "t1_drain");
        chk("t1_beats", 32'(adr_log.size()), 32'd4);
        chk("t1_adr0", adr_log[0], 32'h0000_0100);
        chk("t1_adr3", adr_log[3], 32'h0000_010C);
        chk("t1_cti0", 32'(cti_log[0]), 32'd2);
        chk("t1_cti3", 32'(cti_log[3]), 32'd7);
        chk("t1_pops", 32'(pop_count), 32'd4);
        chk("t1_first", first_pop, 32'h0100_FEFF);

        // Zero-length job
        go(32'h0000_0200, 16'd0);
        wait_done(5, "t2_done");
        repeat (3) @(negedge clk);
        chk("t2_busy", 32'(busy), 32'd0);

        // Back-pressure: FIFO fills to 15 then resumes
        dout_ready = 1'b0; pop_count = 0;
        go(32'h0000_2000, 16'd40);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wb_cyc && !wb_stb) begin
                seen = 1;
                break;
            end
        end
        chk("t3_stall_seen", 32'(seen), 32'd1);
        chk("t3_stall_adr", wb_adr, 32'h0000_203C);
        chk("t3_level", 32'(q.size()), 32'd15);
        repeat (3) @(negedge clk);
        chk("t3_cyc_held", 32'(wb_cyc), 32'd1);
        @(posedge clk); #1 dout_ready = 1'b1;
        wait_done(200, "t3_done");
        wait_drain(50, "t3_drain");
        chk("t3_pops", 32'(pop_count), 32'd40);

        // Error on beat 3 of 8
        dout_ready = 1'b0; err_addr = 32'h0000_4008;
        go(32'h0000_4000, 16'd8);
        wait_done(50, "t4_done");
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_level", 32'(q.size()), 32'd2);
        @(posedge clk); #1 err_addr = 32'hFFFF_FFFF; dout_ready = 1'b1;
        wait_drain(50, "t4_drain");
        go(32'h0000_5000, 16'd1);
        @(negedge clk);
        chk("t4_error_clr", 32'(error), 32'd0);
        wait_done(50, "t4b_done");
        wait_drain(50, "t4b_drain");

        // Reset mid-burst
        go(32'h0000_3000, 16'd10);
        for (int i = 0; i < 50 && beat < 4; i++) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("t5_cyc_now", 32'(wb_cyc), 32'd0);
        chk("t5_valid_now", 32'(dout_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pop_count = 0;
        go(32'h0000_3000, 16'd10);
        wait_done(50, "t5_done");
        wait_drain(50, "t5_drain");
        chk("t5_pops", 32'(pop_count), 32'd10);

        // Start while busy is ignored
        adr_log.delete(); pop_count = 0;
        go(32'h0000_6000, 16'd6);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h0000_7000; word_count = 16'd2;
        @(posedge clk); #1 start = 1'b0;
        wait_done(50, "t6_done");
        wait_drain(50, "t6_drain");
        chk("t6_pops", 32'(pop_count), 32'd6);
        chk("t6_adr5", adr_log[5], 32'h0000_6014);

        // Unaligned base, address wrap, slave wait states
        wait_en = 1'b1; adr_log.delete();
        go(32'hFFFF_FFF9, 16'd4);
        wait_done(50, "t7_done");
        wait_drain(50, "t7_drain");
        chk("t7_adr0", adr_log[0], 32'hFFFF_FFF8);
        chk("t7_adr2", adr_log[2], 32'h0000_0000);
        wait_en = 1'b0;

        // Two jobs appended in the FIFO without draining in between
        dout_ready = 1'b0; pop_count = 0;
        go(32'h0000_8000, 16'd3);
        wait_done(50, "t8a_done");
        go(32'h0000_9000, 16'd3);
        wait_done(50, "t8b_done");
        chk("t8_level", 32'(q.size()), 32'd6);
        @(posedge clk); #1 dout_ready = 1'b1;
        wait_drain(50, "t8_drain");
        chk("t8_pops", 32'(pop_count), 32'd6);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
